line_raster_ctrl: RTL and testbench
===================================

// Module: line_raster_ctrl
// PURPOSE
// - Sequencer for the line-stepping datapath: accepts one segment (x0,y0)->(x1,y1) per handshake.
// - Orders endpoints, runs the shared divider once per segment for the slope, then steps x by one.
// - Each pixel (x, y) goes to the global pixel memory through a write request/acknowledge port.
// - Sits between vertex fetch and globalMem; owns the divider for the whole segment.
// PARAMETERS
// - CW    4  coordinate width, unsigned
// - FRAC  4  fractional bits of the divider quotient (FRAC>=1)
// - AW    8  pixel memory address width
// - BASE  0  first memory address written after reset
// PORTS
// - c         in   1       clock, all logic on rising edge
// - rst       in   1       synchronous active-high reset
// - in_valid  in   1       segment available
// - in_ready  out  1       high only in IDLE
// - v1x,v1y   in   CW      endpoint 1
// - v2x,v2y   in   CW      endpoint 2
// - div_start out  1       one-cycle divide request
// - div_num   out  CW+1    signed dy
// - div_den   out  CW      dx (never 0 when div_start=1)
// - div_done  in   1       quotient valid, single-cycle pulse
// - div_quot  in   CW+2+FRAC  signed slope, FRAC fraction bits
// - mem_we    out  1       pixel write request
// - mem_addr  out  AW      write address
// - mem_x     out  CW      pixel x
// - mem_y     out  CW      pixel y
// - mem_ack   in   1       write accepted this cycle
// - busy      out  1       not IDLE
// - done      out  1       one-cycle pulse at segment end
// BEHAVIOUR
// - Reset: state IDLE; in_ready=1; div_start, mem_we, busy, done = 0; mem_addr=BASE; others 0.
// - Accept: in_valid & in_ready latches endpoints, then SETUP.
// - SETUP (1 cyc): swap endpoints if v1x>v2x; dx=x1-x0; dy=y1-y0 (signed CW+1).
// -   acc = y0<<FRAC.
// -   dx==0 -> WRITE with quot=0, no div_start; only the single pixel (x0,y0) is written.
// -   else -> DIV.
// - DIV: div_start=1 for exactly 1 cycle; div_num/div_den stable from DIV until exit of DIV_WAIT.
// - DIV_WAIT: capture div_quot on div_done, then WRITE. div_done is ignored in every other state.
// - WRITE: mem_we=1; mem_x=x; mem_y=(acc+(1<<(FRAC-1)))>>FRAC, low CW bits.
// -   Outputs held stable while mem_ack=0.
// -   On mem_ack: mem_addr++ (wraps mod 2^AW); if x==x1 -> DONE, else x++, acc+=quot.
// -   With mem_ack tied high: 1 pixel per cycle.
// - DONE (1 cyc): done=1, then IDLE. mem_addr is NOT reset between segments.
// - Pixel count = dx+1. First write occurs 2 cycles after accept when dx==0.
// - acc width CW+3+FRAC, two's complement, no overflow for legal inputs.
// - Reset mid-operation: IDLE next edge; mem_we drops; pending divider result discarded.
// CONFIGURATION
// - CLIP_EN defined:
// -   Adds inputs win_ymin, win_ymax (CW each).
// -   A pixel with y outside [win_ymin, win_ymax] is skipped: mem_we stays 0 that cycle.
// -   A skipped pixel does not advance mem_addr; stepping continues as if acked.
// -   Window sampled at accept.
// - CLIP_EN undefined: ports absent; every pixel written.
// TESTING
// - Divider model 3-cycle latency, FRAC=4, ack tied 1.
// - (1,1)->(5,3): quot=8 -> writes (1,1)(2,2)(3,2)(4,3)(5,3) at addr 0..4; done once.
// - (5,3)->(1,1): identical writes to 1; next addr continues at 5 (no reset between segments).
// - (4,2)->(4,9): no div_start; one write (4,2); done 3 cycles after accept.
// - Backpressure: ack low 2 cycles on the 3rd pixel -> mem_x/mem_y/mem_addr stable, then resume.
// - rst asserted in DIV_WAIT, div_done arrives next cycle -> no mem_we; in_ready=1; mem_addr=BASE.
// - CLIP_EN, win=[2,15], (1,1)->(5,3) -> 4 writes (2,2)(3,2)(4,3)(5,3) at addr 0..3.

Source files
------------

// File: rtl/line_raster_ctrl_if.sv
// Bundle of the segment handshake, the shared-divider port and the pixel-memory write port.
// The controller takes the master modport; the surrounding fabric takes the slave modport.
interface line_raster_ctrl_if #(
   parameter int CW   = 4,
   parameter int FRAC = 4,
   parameter int AW   = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [CW-1:0]            v1x;
   logic [CW-1:0]            v1y;
   logic [CW-1:0]            v2x;
   logic [CW-1:0]            v2y;

   logic                     div_start;
   logic signed [CW:0]       div_num;
   logic [CW-1:0]            div_den;
   logic                     div_done;
   logic signed [CW+1+FRAC:0] div_quot;

   logic                     mem_we;
   logic [AW-1:0]            mem_addr;
   logic [CW-1:0]            mem_x;
   logic [CW-1:0]            mem_y;
   logic                     mem_ack;

   modport master (
      input  in_valid, v1x, v1y, v2x, v2y, div_done, div_quot, mem_ack,
      output in_ready, div_start, div_num, div_den, mem_we, mem_addr, mem_x, mem_y
   );

   modport slave (
      output in_valid, v1x, v1y, v2x, v2y, div_done, div_quot, mem_ack,
      input  in_ready, div_start, div_num, div_den, mem_we, mem_addr, mem_x, mem_y
   );
endinterface

// File: rtl/line_raster_ctrl.sv
// Line-segment sequencer: orders endpoints, fetches the slope from the shared divider, steps x
// and writes one pixel per x. Define CLIP_EN to add the y clipping window (win_ymin/win_ymax).
module line_raster_ctrl #(
   parameter int          CW   = 4,
   parameter int          FRAC = 4,
   parameter int          AW   = 8,
   parameter int unsigned BASE = 0
) (
   input  logic                c,
   input  logic                rst,
   line_raster_ctrl_if.master  bus,
`ifdef CLIP_EN
   input  logic [CW-1:0]       win_ymin,
   input  logic [CW-1:0]       win_ymax,
`endif
   output logic                busy,
   output logic                done
);
   localparam int ACCW   = CW + 3 + FRAC;
   localparam int HALF_I = 1 << (FRAC - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_DIV      = 3'd2;
   localparam logic [2:0] S_DIV_WAIT = 3'd3;
   localparam logic [2:0] S_WRITE    = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]             state_reg;
   logic [CW-1:0]          p1x_reg, p1y_reg, p2x_reg, p2y_reg;
   logic [CW-1:0]          x_reg, x1_reg;
   logic signed [ACCW-1:0] acc_reg;
   logic signed [ACCW-1:0] quot_reg;
   logic signed [CW:0]     num_reg;
   logic [CW-1:0]          den_reg;
   logic [AW-1:0]          addr_reg;

   logic                   swap;
   logic [CW-1:0]          sx0, sy0, sx1, sy1, dx;
   logic signed [CW:0]     dy;
   logic signed [ACCW-1:0] acc_init;
   logic signed [ACCW-1:0] acc_rnd;
   logic [CW-1:0]          pix_y;
   logic                   in_win;
   logic                   write_st;
   logic                   step;

   // Endpoint ordering and deltas are derived from the latched segment during SETUP.
   always_comb begin
      swap     = p1x_reg > p2x_reg;
      sx0      = swap ? p2x_reg : p1x_reg;
      sy0      = swap ? p2y_reg : p1y_reg;
      sx1      = swap ? p1x_reg : p2x_reg;
      sy1      = swap ? p1y_reg : p2y_reg;
      dx       = sx1 - sx0;
      dy       = $signed({1'b0, sy1}) - $signed({1'b0, sy0});
      acc_init = $signed({3'b000, sy0, {FRAC{1'b0}}});
   end

   // Round-to-nearest of the fixed-point y accumulator.
   always_comb begin
      acc_rnd = acc_reg + $signed(ACCW'(HALF_I));
      pix_y   = CW'(acc_rnd >>> FRAC);
   end

`ifdef CLIP_EN
   logic [CW-1:0] ymin_reg, ymax_reg;

   always_ff @(posedge c) begin
      if (rst) begin
         ymin_reg <= '0;
         ymax_reg <= '0;
      end else if (state_reg == S_IDLE && bus.in_valid) begin
         ymin_reg <= win_ymin;
         ymax_reg <= win_ymax;
      end
   end

   assign in_win = (pix_y >= ymin_reg) && (pix_y <= ymax_reg);
`else
   assign in_win = 1'b1;
`endif

   // A clipped pixel advances the stepper as though it had been acknowledged.
   assign write_st = (state_reg == S_WRITE);
   assign step     = write_st && (bus.mem_ack || !in_win);

   always_ff @(posedge c) begin
      if (rst) begin
         state_reg <= S_IDLE;
         p1x_reg   <= '0;
         p1y_reg   <= '0;
         p2x_reg   <= '0;
         p2y_reg   <= '0;
         x_reg     <= '0;
         x1_reg    <= '0;
         acc_reg   <= '0;
         quot_reg  <= '0;
         num_reg   <= '0;
         den_reg   <= '0;
         addr_reg  <= AW'(BASE);
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.in_valid) begin
                  p1x_reg   <= bus.v1x;
                  p1y_reg   <= bus.v1y;
                  p2x_reg   <= bus.v2x;
                  p2y_reg   <= bus.v2y;
                  state_reg <= S_SETUP;
               end
            end
            S_SETUP: begin
               x_reg   <= sx0;
               x1_reg  <= sx1;
               acc_reg <= acc_init;
               num_reg <= dy;
               den_reg <= dx;
               if (dx == '0) begin
                  quot_reg  <= '0;
                  state_reg <= S_WRITE;
               end else begin
                  state_reg <= S_DIV;
               end
            end
            S_DIV: begin
               state_reg <= S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
               if (bus.div_done) begin
                  quot_reg  <= {bus.div_quot[CW+1+FRAC], bus.div_quot};
                  state_reg <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (step) begin
                  if (in_win) begin
                     addr_reg <= addr_reg + AW'(1);
                  end
                  if (x_reg == x1_reg) begin
                     state_reg <= S_DONE;
                  end else begin
                     x_reg   <= x_reg + CW'(1);
                     acc_reg <= acc_reg + quot_reg;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == S_IDLE);
   assign bus.div_start = (state_reg == S_DIV);
   assign bus.div_num   = num_reg;
   assign bus.div_den   = den_reg;
   assign bus.mem_we    = write_st && in_win;
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_x     = x_reg;
   assign bus.mem_y     = pix_y;
   assign busy          = (state_reg != S_IDLE);
   assign done          = (state_reg == S_DONE);
endmodule

// File: tb/tb_line_raster_ctrl.sv
// Directed bench for line_raster_ctrl: segment table with expected pixel lists, plus hand
// sequences for backpressure, reset during the divide and (with CLIP_EN) the y window.
module tb_line_raster_ctrl;
   localparam int CW   = 4;
   localparam int FRAC = 4;
   localparam int AW   = 8;

   typedef struct packed {
      logic [3:0]  v1x;
      logic [3:0]  v1y;
      logic [3:0]  v2x;
      logic [3:0]  v2y;
      int          npix;
      bit          use_div;
      logic [31:0] ex;
      logic [31:0] ey;
   } vec_t;

   logic c = 1'b0;
   logic rst = 1'b1;
   logic busy, done;
   int   ncmp = 0;
   int   nerr = 0;
   int   exp_addr = 0;

   always #5 c = ~c;

   line_raster_ctrl_if #(.CW(CW), .FRAC(FRAC), .AW(AW)) bus ();

`ifdef CLIP_EN
   logic [CW-1:0] win_ymin = 4'd0;
   logic [CW-1:0] win_ymax = 4'd15;
`endif

   line_raster_ctrl #(.CW(CW), .FRAC(FRAC), .AW(AW), .BASE(0)) dut (
      .c        (c),
      .rst      (rst),
      .bus      (bus),
`ifdef CLIP_EN
      .win_ymin (win_ymin),
      .win_ymax (win_ymax),
`endif
      .busy     (busy),
      .done     (done)
   );

   // Divider model: 3-cycle latency, quotient truncated toward zero, not reset by rst.
   int                  dcnt = 0;
   logic signed [CW:0]  dnum = '0;
   logic [CW-1:0]       dden = '0;
   int                  dq;

   always @(posedge c) begin
      if (bus.div_start) begin
         dcnt <= 3;
         dnum <= bus.div_num;
         dden <= bus.div_den;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
      end
   end

   assign bus.div_done = (dcnt == 1);

   always_comb begin
      dq = 0;
      if (dden != '0) dq = (int'(dnum) * (1 << FRAC)) / int'({1'b0, dden});
      bus.div_quot = dq[CW+1+FRAC:0];
   end

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int ax, input int ay, input int bx, input int by,
                               input int np, input bit ud, input logic [31:0] ex,
                               input logic [31:0] ey);
      vec_t v;
      v.v1x = ax[3:0];
      v.v1y = ay[3:0];
      v.v2x = bx[3:0];
      v.v2y = by[3:0];
      v.npix = np;
      v.use_div = ud;
      v.ex = ex;
      v.ey = ey;
      return v;
   endfunction

   task automatic run_seg(input vec_t v, input int hold_idx, input string nm);
      int n, nw, nd, nds, first_n, last_n, done_n, stalls, exp_dx, exp_dy;
      bit ended, rdy;
      logic [3:0] hx, hy, ex, ey;
      logic [AW-1:0] ha;
      logic [31:0] exv, eyv;
      n = 0; nw = 0; nd = 0; nds = 0; first_n = 0; last_n = 0; done_n = 0; stalls = 0;
      ended = 0; rdy = 0; hx = '0; hy = '0; ha = '0;
      exv = v.ex; eyv = v.ey;
      for (int i = 0; i < 20 && !rdy; i++) begin
         @(negedge c);
         rdy = bus.in_ready;
      end
      chk({nm, " in_ready before accept"}, int'(rdy), 1);
      if (v.v1x > v.v2x) begin
         exp_dx = int'(v.v1x) - int'(v.v2x);
         exp_dy = int'(v.v1y) - int'(v.v2y);
      end else begin
         exp_dx = int'(v.v2x) - int'(v.v1x);
         exp_dy = int'(v.v2y) - int'(v.v1y);
      end
      bus.v1x = v.v1x; bus.v1y = v.v1y; bus.v2x = v.v2x; bus.v2y = v.v2y;
      bus.in_valid = 1'b1;
      @(negedge c);
      bus.in_valid = 1'b0;
      n = 1;
      while (!ended && n < 80) begin
         if (bus.div_start) begin
            nds++;
            chk({nm, " div_den"}, int'(bus.div_den), exp_dx);
            chk({nm, " div_num"}, int'(bus.div_num), exp_dy);
         end
         if (bus.mem_we) begin
            if (nw == hold_idx && stalls < 2) begin
               bus.mem_ack = 1'b0;
               if (stalls == 0) begin
                  hx = bus.mem_x; hy = bus.mem_y; ha = bus.mem_addr;
               end else begin
                  chk({nm, " stall x"}, int'(bus.mem_x), int'(hx));
                  chk({nm, " stall y"}, int'(bus.mem_y), int'(hy));
                  chk({nm, " stall addr"}, int'(bus.mem_addr), int'(ha));
               end
               stalls++;
            end else begin
               bus.mem_ack = 1'b1;
               if (stalls > 0 && nw == hold_idx)
                  chk({nm, " post-stall addr"}, int'(bus.mem_addr), int'(ha));
               if (nw < 8) begin
                  ex = exv[nw*4 +: 4];
                  ey = eyv[nw*4 +: 4];
                  chk($sformatf("%s px%0d x", nm, nw), int'(bus.mem_x), int'(ex));
                  chk($sformatf("%s px%0d y", nm, nw), int'(bus.mem_y), int'(ey));
               end
               chk($sformatf("%s px%0d addr", nm, nw), int'(bus.mem_addr), exp_addr % 256);
               if (nw == 0) first_n = n;
               last_n = n;
               nw++;
               exp_addr++;
            end
         end else begin
            bus.mem_ack = 1'b1;
         end
         if (done) begin
            nd++;
            done_n = n;
            ended = 1;
         end else begin
            @(negedge c);
            n++;
         end
      end
      bus.mem_ack = 1'b1;
      chk({nm, " done seen"}, int'(ended), 1);
      chk({nm, " pixel count"}, nw, v.npix);
      chk({nm, " div_start count"}, nds, v.use_div ? 1 : 0);
      chk({nm, " write span"}, last_n - first_n, v.npix - 1 + stalls);
      chk({nm, " done after last write"}, done_n - last_n, 1);
      if (!v.use_div) begin
         chk({nm, " first write cycle"}, first_n, 2);
         chk({nm, " done cycle"}, done_n, 3);
      end
      @(negedge c);
      chk({nm, " in_ready after done"}, int'(bus.in_ready), 1);
      chk({nm, " busy after done"}, int'(busy), 0);
      chk({nm, " done single pulse"}, int'(done), 0);
      $display("seg %s (%0d,%0d)->(%0d,%0d): %0d writes, %0d stalls, done at cycle %0d",
               nm, v.v1x, v.v1y, v.v2x, v.v2y, nw, stalls, done_n);
   endtask

   vec_t tbl [9];

   initial begin
      bit got;
      tbl[0] = mk(1, 1, 5, 3, 5, 1, 32'h00054321, 32'h00033221);
      tbl[1] = mk(5, 3, 1, 1, 5, 1, 32'h00054321, 32'h00033221);
      tbl[2] = mk(4, 2, 4, 9, 1, 0, 32'h00000004, 32'h00000002);
      tbl[3] = mk(0, 5, 4, 1, 5, 1, 32'h00043210, 32'h00012345);
      tbl[4] = mk(0, 0, 3, 2, 4, 1, 32'h00003210, 32'h00002110);
      tbl[5] = mk(3, 0, 0, 2, 4, 1, 32'h00003210, 32'h00000112);
      tbl[6] = mk(0, 0, 7, 7, 8, 1, 32'h76543210, 32'h76543210);
      tbl[7] = mk(9, 7, 9, 1, 1, 0, 32'h00000009, 32'h00000007);
      tbl[8] = mk(2, 6, 6, 6, 5, 1, 32'h00065432, 32'h00066666);

      bus.in_valid = 1'b0;
      bus.v1x = '0; bus.v1y = '0; bus.v2x = '0; bus.v2y = '0;
      bus.mem_ack = 1'b1;
      repeat (3) @(negedge c);
      chk("reset in_ready", int'(bus.in_ready), 1);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset mem_we", int'(bus.mem_we), 0);
      chk("reset div_start", int'(bus.div_start), 0);
      chk("reset mem_addr", int'(bus.mem_addr), 0);
      chk("reset mem_x", int'(bus.mem_x), 0);
      chk("reset mem_y", int'(bus.mem_y), 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_seg(tbl[i], -1, $sformatf("tbl%0d", i));

      run_seg(tbl[0], 2, "backpressure");

      // Reset while waiting on the divider; the late div_done must be ignored.
      got = 0;
      @(negedge c);
      bus.v1x = 4'd1; bus.v1y = 4'd1; bus.v2x = 4'd5; bus.v2y = 4'd3;
      bus.in_valid = 1'b1;
      @(negedge c);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (bus.div_start) got = 1;
         else @(negedge c);
      end
      chk("rst-test div_start seen", int'(got), 1);
      @(negedge c);
      @(negedge c);
      rst = 1'b1;
      @(negedge c);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rst-test mem_we c%0d", i), int'(bus.mem_we), 0);
         chk($sformatf("rst-test in_ready c%0d", i), int'(bus.in_ready), 1);
         chk($sformatf("rst-test busy c%0d", i), int'(busy), 0);
         chk($sformatf("rst-test mem_addr c%0d", i), int'(bus.mem_addr), 0);
         @(negedge c);
      end
      $display("seg rst-in-div-wait: returned to idle with mem_addr=%0d", bus.mem_addr);
      exp_addr = 0;

`ifdef CLIP_EN
      win_ymin = 4'd2;
      win_ymax = 4'd15;
      run_seg(mk(1, 1, 5, 3, 4, 1, 32'h00005432, 32'h00003322), -1, "clip");
      win_ymin = 4'd0;
`endif

      run_seg(tbl[5], -1, "post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
